seq_tx_serializer: RTL and testbench

Serial pattern transmitter: the sending end of the single-bit stream consumed by the sequence-detector FSM. On a `start` request it captures an N-bit pattern from the board switches and shifts it out MSB-first, one bit per prescaled bit period. Each bit period ends with a one-cycle `x_strobe`, which marks the cycle in which the receiver samples `x`. The block sits between the switch/button inputs and the detector, replacing the free-running switch multiplexer with a handshaken, framed source.

---
 rtl/seq_tx_serializer.sv | 122 ++++++++++++
 tb/tb_seq_tx_serializer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_tx_serializer.sv
// Framed serial pattern transmitter: captures an N-bit pattern on start and shifts it out MSB-first,
// one bit per TICK_CNT clocks, with a strobe on the last cycle of each bit. Optional SEQ_TX_REPEAT_EN.
`timescale 1ns/1ps

// state   | meaning
// S_IDLE  | waiting for start; all outputs low
// S_SHIFT | frame in progress; x carries shreg MSB
// S_DONE  | single-cycle done pulse after the final bit
module seq_tx_serializer #(
    parameter int N        = 8,
    parameter int TICK_CNT = 25_000_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         pattern,
    input  logic                 start,
    input  logic                 repeat_req,
    output logic                 x,
    output logic                 x_strobe,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(N)-1:0] bit_idx,
    output logic [N-1:0]         leds
);

    localparam int BW = $clog2(N);
    localparam int PW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(TICK_CNT - 1);
    localparam logic [BW-1:0] B_MSB   = BW'(N - 1);
    localparam logic [N-1:0]  LED_MSB = {1'b1, {(N-1){1'b0}}};
    // With a single-cycle bit period every shift cycle is also a strobe cycle.
    localparam logic STROBE_ON_LOAD = (TICK_CNT == 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t          state;
    logic [N-1:0]    shreg;
    logic [PW-1:0]   pcnt;
    logic [PW-1:0]   pcnt_inc;

    assign pcnt_inc = pcnt + PW'(1);

`ifdef SEQ_TX_REPEAT_EN
    logic [N-1:0]    cap;
`else
    logic            unused_repeat;
    assign unused_repeat = repeat_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            shreg    <= '0;
            pcnt     <= '0;
            x        <= 1'b0;
            x_strobe <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bit_idx  <= '0;
            leds     <= '0;
`ifdef SEQ_TX_REPEAT_EN
            cap      <= '0;
`endif
        end else begin
            x_strobe <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_SHIFT;
                        shreg    <= pattern;
`ifdef SEQ_TX_REPEAT_EN
                        cap      <= pattern;
`endif
                        pcnt     <= '0;
                        bit_idx  <= B_MSB;
                        x        <= pattern[N-1];
                        busy     <= 1'b1;
                        leds     <= LED_MSB;
                        x_strobe <= STROBE_ON_LOAD;
                    end
                end
                S_SHIFT: begin
                    if (pcnt == P_LAST) begin
                        pcnt <= '0;
                        if (bit_idx != '0) begin
                            shreg    <= {shreg[N-2:0], 1'b0};
                            x        <= shreg[N-2];
                            bit_idx  <= bit_idx - BW'(1);
                            leds     <= leds >> 1;
                            x_strobe <= STROBE_ON_LOAD;
                        end
`ifdef SEQ_TX_REPEAT_EN
                        // Repeat replays the captured pattern, never the live switches.
                        else if (repeat_req) begin
                            shreg    <= cap;
                            x        <= cap[N-1];
                            bit_idx  <= B_MSB;
                            leds     <= LED_MSB;
                            x_strobe <= STROBE_ON_LOAD;
                        end
`endif
                        else begin
                            state <= S_DONE;
                            shreg <= '0;
                            x     <= 1'b0;
                            busy  <= 1'b0;
                            leds  <= '0;
                            done  <= 1'b1;
                        end
                    end else begin
                        pcnt     <= pcnt_inc;
                        x_strobe <= (pcnt_inc == P_LAST);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_tx_serializer.sv
// Bench for seq_tx_serializer (N=8, TICK_CNT=4): per-cycle reference model plus a bit scoreboard
// filled when a frame is requested and drained on each x_strobe.
`timescale 1ns/1ps

module tb_seq_tx_serializer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic       start = 1'b0;
    logic       repeat_req = 1'b0;
    logic       x, x_strobe, busy, done;
    logic [2:0] bit_idx;
    logic [7:0] leds;

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];

    seq_tx_serializer #(.N(8), .TICK_CNT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pattern    (pattern),
        .start      (start),
        .repeat_req (repeat_req),
        .x          (x),
        .x_strobe   (x_strobe),
        .busy       (busy),
        .done       (done),
        .bit_idx    (bit_idx),
        .leds       (leds)
    );

    always #5 clk = ~clk;

    wire [14:0] obs = {x, x_strobe, busy, done, bit_idx, leds};

    // Expected outputs in cycle m of a frame (m=1 is the cycle after start is sampled).
    function automatic logic [14:0] model(input int m, input logic [7:0] pat);
        logic [14:0] r;
        int k;
        r = '0;
        if (m >= 1 && m <= 32) begin
            k = (m - 1) / 4;
            r = {pat[7-k], (m % 4 == 0), 1'b1, 1'b0, 3'(7 - k), 8'(1 << (7 - k))};
        end else if (m == 33) begin
            r = {4'b0001, 3'd0, 8'd0};
        end
        return r;
    endfunction

    task automatic push_frame(input logic [7:0] pat);
        for (int i = 7; i >= 0; i--) exp_q.push_back(pat[i]);
    endtask

    always @(negedge clk) begin
        if (reset_n && x_strobe) begin : sb
            logic e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: strobe with x=%0b but no bit expected", x);
            end else begin
                e = exp_q.pop_front();
                if (x !== e) begin
                    errors++;
                    $display("FAIL sb_bit: x=%0b expected %0b", x, e);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h expected 0", obs);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== 15'd0) begin
                errors++;
                $display("FAIL reset_idle c=%0d: outputs=%h expected 0", c, obs);
            end
        end
    endtask

    task automatic test_frame(input logic [7:0] pat, input bit disturb);
        @(negedge clk);
        pattern = pat;
        start   = 1'b1;
        push_frame(pat);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            if (c > 1) @(negedge clk);
            checks++;
            if (obs !== model(c, pat)) begin
                errors++;
                $display("FAIL frame_%h c=%0d: outputs=%h expected %h", pat, c, obs, model(c, pat));
            end
            if (disturb && c == 10) begin
                pattern = 8'h00;
                start   = 1'b1;
            end
            if (c == 11) start = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        pattern = 8'hB4;
        start   = 1'b1;
        push_frame(8'hB4);
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        checks++;
        if (bit_idx !== 3'd4) begin
            errors++;
            $display("FAIL mid_pre: bit_idx=%0d expected 4", bit_idx);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL mid_reset: outputs=%h expected 0", obs);
        end
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== 15'd0) begin
                errors++;
                $display("FAIL mid_after c=%0d: outputs=%h expected 0", c, obs);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] e;
        @(negedge clk);
        pattern = 8'hFF;
        start   = 1'b1;
        push_frame(8'hFF);
        push_frame(8'hFF);
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            e = (c <= 68) ? model((c - 1) % 34 + 1, 8'hFF) : 15'd0;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL b2b c=%0d: outputs=%h expected %h", c, obs, e);
            end
            if (c == 50) start = 1'b0;
        end
    endtask

`ifdef SEQ_TX_REPEAT_EN
    task automatic test_repeat();
        logic [14:0] e;
        @(negedge clk);
        pattern    = 8'h81;
        start      = 1'b1;
        repeat_req = 1'b1;
        push_frame(8'h81);
        push_frame(8'h81);
        for (int c = 1; c <= 68; c++) begin
            @(negedge clk);
            e = (c <= 65) ? model((c <= 32) ? c : c - 32, 8'h81) : 15'd0;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL repeat c=%0d: outputs=%h expected %h", c, obs, e);
            end
            if (c == 1)  start = 1'b0;
            if (c == 5)  pattern = 8'h00;
            if (c == 40) repeat_req = 1'b0;
        end
    endtask
`endif

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame(8'hB4, 1'b0);
        test_frame(8'hB4, 1'b1);
        test_reset_mid();
        test_back_to_back();
`ifdef SEQ_TX_REPEAT_EN
        test_repeat();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d bits still queued, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
